inband_ring_fetch: RTL and testbench
====================================

// Module: inband_ring_fetch
// PURPOSE
//  Consumer of the inband command ring programmed through the DCR host interface. Compares the
//  host producer index with its own consumer index, fetches each 32-byte descriptor from system
//  memory over a simple read master, and buffers it in an internal FIFO for the SATA port logic.
//  After each descriptor it writes the consumer index back to memory and returns it to the host
//  interface as inband_cons_index.
// PARAMETERS
//  C_RING_ENTRIES  256  ring size in descriptors, power of 2, 2..4096
//  C_FIFO_DEPTH    16   descriptor FIFO depth in 32-bit words, power of 2, >= 8
// PORTS
//  sys_clk            in   1   block clock
//  sys_rst_n          in   1   asynchronous active-low reset
//  ring_enable        in   1   ring run enable from host interface
//  inband_base        in   32  ring base byte address, 32-byte aligned
//  inband_cons_addr   in   32  byte address for consumer-index write-back
//  inband_prod_index  in   12  host producer index
//  inband_cons_index  out  12  current consumer index
//  rd_req             out  1   memory read request, held until rd_ack
//  rd_addr            out  32  read byte address
//  rd_ack             in   1   read request accepted
//  rd_data            in   32  read data word
//  rd_data_valid      in   1   rd_data valid; exactly 8 beats per request, cannot be stalled
//  wr_req             out  1   write-back request, held until wr_ack
//  wr_addr            out  32  write-back byte address
//  wr_data            out  32  write-back data
//  wr_ack             in   1   write-back complete
//  desc_data          out  32  descriptor word to consumer
//  desc_valid         out  1   desc_data valid
//  desc_last          out  1   marks word 7 of a descriptor
//  desc_ready         in   1   consumer accepts the word when desc_valid and desc_ready are both 1
// BEHAVIOUR
//  - Reset: FSM=IDLE, inband_cons_index=0, FIFO empty. rd_req, wr_req, desc_valid and desc_last
//    are 0. rd_addr, wr_addr and wr_data are 0.
//  - Index math: index width is log2(C_RING_ENTRIES). inband_prod_index is used modulo
//    C_RING_ENTRIES; upper bits are ignored. The consumer index increments modulo C_RING_ENTRIES,
//    so it wraps from C_RING_ENTRIES-1 to 0.
//    rd_addr = inband_base + {cons, 5'b0}.
//  - FSM states:
//    IDLE: if ring_enable=0, hold cons=0 and flush the FIFO.
//      Go to RD_REQ when ring_enable=1, prod mod N != cons, and FIFO free >= 8.
//      Producer index is sampled only in IDLE.
//    RD_REQ: assert rd_req with rd_addr stable. On rd_ack go to RD_DATA.
//    RD_DATA: push each rd_data_valid beat into the FIFO; count beats 0..7.
//      On beat 7, cons <= cons+1 and go to WB_REQ.
//    WB_REQ: wr_req=1, wr_addr=inband_cons_addr, wr_data={20'b0, cons}. On wr_ack go to IDLE.
//  - inband_cons_index updates on the same clock edge as beat 7, one cycle before wr_req rises.
//  - FIFO free space is reserved before the request, so overflow cannot occur.
//    A push and a pop in the same cycle keep the occupancy unchanged.
//  - FIFO output: first-word latency is 1 cycle after push. desc_valid=1 whenever the FIFO is
//    non-empty. desc_data and desc_last must stay stable while desc_valid=1 and desc_ready=0.
//  - ring_enable falling mid-operation: finish the current read burst and write-back, then enter
//    IDLE and clear cons and the FIFO. Bus transactions are never abandoned.
//  - Only one outstanding read at a time. No new read is issued until the write-back is acked.
// TESTING
//  1. Reset, ring_enable=1, base=0x1000, prod=1. Expect rd_addr=0x1000, 8 words out with
//     desc_last on word 8, wr_data=1 at cons_addr, and inband_cons_index=1.
//  2. C_RING_ENTRIES=4, cons=3, prod=1. Expect fetches at base+0x60 then base+0x00,
//     and inband_cons_index goes 0 then 1.
//  3. Hold desc_ready=0 with prod=5 and C_FIFO_DEPTH=16. Expect exactly 2 descriptors fetched,
//     then rd_req stays 0. Release desc_ready: remaining 3 are fetched, with no drop or duplicate.
//  4. Stall rd_ack for 20 cycles. Expect rd_req and rd_addr stable throughout. Same check for
//     wr_req and wr_data against wr_ack.
//  5. Drop ring_enable at RD_DATA beat 3. Expect beats 4-7 consumed and the write-back
//     completed, then cons=0 and FIFO empty with desc_valid=0.
//  6. Assert sys_rst_n=0 mid-burst. Expect all outputs immediately at reset values and
//     inband_cons_index=0.

Source files
------------

// File: rtl/inband_ring_fetch_if.sv
// Host, memory-read, write-back and descriptor-stream signals of the inband ring fetcher.
// Latency: pure wiring, none of its own.
// Backpressure: rd/wr requests held until ack; descriptor stream is valid/ready.
interface inband_ring_fetch_if;
    logic        ring_enable;
    logic [31:0] inband_base;
    logic [31:0] inband_cons_addr;
    logic [11:0] inband_prod_index;
    logic [11:0] inband_cons_index;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic        rd_data_valid;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic [31:0] desc_data;
    logic        desc_valid;
    logic        desc_last;
    logic        desc_ready;

    // Fetch engine side.
    modport master (
        input  ring_enable, inband_base, inband_cons_addr, inband_prod_index,
        output inband_cons_index,
        output rd_req, rd_addr,
        input  rd_ack, rd_data, rd_data_valid,
        output wr_req, wr_addr, wr_data,
        input  wr_ack,
        output desc_data, desc_valid, desc_last,
        input  desc_ready
    );

    // Host, memory and descriptor-consumer side.
    modport slave (
        output ring_enable, inband_base, inband_cons_addr, inband_prod_index,
        input  inband_cons_index,
        input  rd_req, rd_addr,
        output rd_ack, rd_data, rd_data_valid,
        input  wr_req, wr_addr, wr_data,
        output wr_ack,
        input  desc_data, desc_valid, desc_last,
        output desc_ready
    );
endinterface

// File: rtl/inband_ring_fetch.sv
// Inband command ring consumer: fetches 32-byte descriptors, buffers them, writes back cons index.
// Latency: first descriptor word visible 1 cycle after its read beat is pushed.
// Backpressure: a new read is issued only with 8 free FIFO words; desc stream holds on !desc_ready.
module inband_ring_fetch #(
    parameter int C_RING_ENTRIES = 256,
    parameter int C_FIFO_DEPTH   = 16
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    inband_ring_fetch_if.master        ring
);
    localparam int IW = (C_RING_ENTRIES > 2) ? $clog2(C_RING_ENTRIES) : 1;
    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RD_REQ, S_RD_DATA, S_WB_REQ} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_cons;
    logic [IW-1:0]   w_prod;
    logic [IW-1:0]   w_cons_inc;
    logic [2:0]      r_beat;
    logic            r_wr_req;
    logic [31:0]     r_rd_addr;
    logic [31:0]     r_wr_addr;
    logic [31:0]     r_wr_data;
    logic [32:0]     r_mem [C_FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_room;
    logic            w_launch;
    logic            w_push;
    logic            w_last_beat;
    logic            w_flush;
    logic            w_pop;
    logic            w_desc_vld;

    // Producer index is taken modulo the ring size; its upper bits carry no meaning here.
    assign w_prod     = ring.inband_prod_index[IW-1:0];
    assign w_cons_inc = r_cons + IW'(1);
    generate
        if (IW < 12) begin : g_prod_hi
            logic w_prod_hi_unused;
            assign w_prod_hi_unused = ^ring.inband_prod_index[11:IW];
        end
    endgenerate

    // A full descriptor's worth of space is reserved before the read is issued.
    assign w_room     = (r_count <= CW'(C_FIFO_DEPTH - 8));
    assign w_desc_vld = (r_count != '0);
    assign w_pop      = w_desc_vld && ring.desc_ready;

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    // Next-state decode and per-cycle strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_push      = 1'b0;
        w_last_beat = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!ring.ring_enable) begin
                    w_flush = 1'b1;
                end else if ((w_prod != r_cons) && w_room) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (ring.rd_ack) w_state_nxt = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (ring.rd_data_valid) begin
                    w_push = 1'b1;
                    if (r_beat == 3'd7) begin
                        w_last_beat = 1'b1;
                        w_state_nxt = S_WB_REQ;
                    end
                end
            end
            S_WB_REQ: begin
                if (r_wr_req && ring.wr_ack) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Consumer index: cleared while the ring is disabled in IDLE, advanced on the last beat.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)       r_cons <= '0;
        else if (w_flush)     r_cons <= '0;
        else if (w_last_beat) r_cons <= w_cons_inc;
    end

    // Beat counter within a burst; wraps to 0 after beat 7.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)  r_beat <= '0;
        else if (w_push) r_beat <= r_beat + 3'd1;
    end

    // Read address is frozen at launch so it stays stable while rd_req waits for rd_ack.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)    r_rd_addr <= '0;
        else if (w_launch) r_rd_addr <= ring.inband_base + 32'({r_cons, 5'b0});
    end

    // Write-back payload captured with the new index on the last beat.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (w_last_beat) begin
            r_wr_addr <= ring.inband_cons_addr;
            r_wr_data <= 32'(w_cons_inc);
        end
    end

    // wr_req rises one cycle after the index update and drops on the accepting ack.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                          r_wr_req <= 1'b0;
        else if (r_wr_req && ring.wr_ack)        r_wr_req <= 1'b0;
        else if (r_state == S_WB_REQ)            r_wr_req <= 1'b1;
    end

    // Descriptor storage; bit 32 flags word 7.
    always_ff @(posedge sys_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {w_last_beat, ring.rd_data};
    end

    // FIFO pointers and occupancy; flush while disabled in IDLE wins over everything.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign ring.inband_cons_index = 12'(r_cons);
    assign ring.rd_req            = (r_state == S_RD_REQ);
    assign ring.rd_addr           = r_rd_addr;
    assign ring.wr_req            = r_wr_req;
    assign ring.wr_addr           = r_wr_addr;
    assign ring.wr_data           = r_wr_data;
    assign ring.desc_valid        = w_desc_vld;
    assign ring.desc_data         = w_desc_vld ? r_mem[r_rd_ptr][31:0] : 32'd0;
    assign ring.desc_last         = w_desc_vld && r_mem[r_rd_ptr][32];
endmodule

// File: tb/tb_inband_ring_fetch.sv
`timescale 1ns/1ps
module tb_inband_ring_fetch;
    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rd_stall = 0;
    int   wr_stall = 0;
    bit   hold = 0;

    logic [31:0] a_rd_log[$];
    logic [31:0] a_wr_addr_log[$];
    logic [31:0] a_wr_data_log[$];
    logic [32:0] a_desc_log[$];
    logic [31:0] b_rd_log[$];
    logic [31:0] b_wr_log[$];

    inband_ring_fetch_if ifa();
    inband_ring_fetch_if ifb();

    inband_ring_fetch #(.C_RING_ENTRIES(256), .C_FIFO_DEPTH(16)) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .ring(ifa));
    inband_ring_fetch #(.C_RING_ENTRIES(4), .C_FIFO_DEPTH(16)) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .ring(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory read responder for instance A: data word = burst address + beat.
    initial begin
        logic [31:0] a;
        ifa.rd_ack = 0; ifa.rd_data_valid = 0; ifa.rd_data = 0;
        forever begin
            @(negedge clk);
            if (ifa.rd_req === 1'b1) begin
                repeat (rd_stall) @(negedge clk);
                a = ifa.rd_addr;
                a_rd_log.push_back(a);
                ifa.rd_ack = 1;
                @(negedge clk);
                ifa.rd_ack = 0;
                for (int b = 0; b < 8; b++) begin
                    ifa.rd_data_valid = 1;
                    ifa.rd_data = a + 32'(b);
                    @(negedge clk);
                end
                ifa.rd_data_valid = 0;
                ifa.rd_data = 0;
            end
        end
    end

    // Write-back responder for instance A.
    initial begin
        ifa.wr_ack = 0;
        forever begin
            @(negedge clk);
            if (ifa.wr_req === 1'b1) begin
                repeat (wr_stall) @(negedge clk);
                a_wr_addr_log.push_back(ifa.wr_addr);
                a_wr_data_log.push_back(ifa.wr_data);
                ifa.wr_ack = 1;
                @(negedge clk);
                ifa.wr_ack = 0;
            end
        end
    end

    // Descriptor consumer for instance A; drives ready and logs accepted words together.
    initial begin
        ifa.desc_ready = 0;
        forever begin
            @(negedge clk);
            ifa.desc_ready = !hold;
            if (ifa.desc_valid === 1'b1 && ifa.desc_ready)
                a_desc_log.push_back({ifa.desc_last, ifa.desc_data});
        end
    end

    // Memory responder for instance B (no stalls).
    initial begin
        logic [31:0] a;
        ifb.rd_ack = 0; ifb.rd_data_valid = 0; ifb.rd_data = 0;
        forever begin
            @(negedge clk);
            if (ifb.rd_req === 1'b1) begin
                a = ifb.rd_addr;
                b_rd_log.push_back(a);
                ifb.rd_ack = 1;
                @(negedge clk);
                ifb.rd_ack = 0;
                for (int b = 0; b < 8; b++) begin
                    ifb.rd_data_valid = 1;
                    ifb.rd_data = a + 32'(b);
                    @(negedge clk);
                end
                ifb.rd_data_valid = 0;
            end
        end
    end

    // Write-back responder for instance B; consumer always ready.
    initial begin
        ifb.wr_ack = 0;
        ifb.desc_ready = 1;
        forever begin
            @(negedge clk);
            if (ifb.wr_req === 1'b1) begin
                b_wr_log.push_back(ifb.wr_data);
                ifb.wr_ack = 1;
                @(negedge clk);
                ifb.wr_ack = 0;
            end
        end
    end

    task automatic do_reset();
        rst_n = 0;
        ifa.ring_enable = 0;
        ifa.inband_prod_index = 0;
        hold = 0; rd_stall = 0; wr_stall = 0;
        repeat (3) @(negedge clk);
        a_rd_log.delete(); a_wr_addr_log.delete(); a_wr_data_log.delete(); a_desc_log.delete();
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic wait_a_wr(int n, int budget);
        int k = 0;
        while (a_wr_data_log.size() < n && k < budget) begin @(negedge clk); k++; end
    endtask

    task automatic wait_a_rd_req(int budget);
        int k = 0;
        while (ifa.rd_req !== 1'b1 && k < budget) begin @(negedge clk); k++; end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        n_cmp++; if (ifa.rd_req !== 1'b0) begin n_bad++; $display("FAIL reset_rd_req: got %b want 0", ifa.rd_req); end
        n_cmp++; if (ifa.wr_req !== 1'b0) begin n_bad++; $display("FAIL reset_wr_req: got %b want 0", ifa.wr_req); end
        n_cmp++; if (ifa.desc_valid !== 1'b0) begin n_bad++; $display("FAIL reset_desc_valid: got %b want 0", ifa.desc_valid); end
        n_cmp++; if (ifa.desc_last !== 1'b0) begin n_bad++; $display("FAIL reset_desc_last: got %b want 0", ifa.desc_last); end
        n_cmp++; if (ifa.rd_addr !== 32'h0) begin n_bad++; $display("FAIL reset_rd_addr: got %h want 0", ifa.rd_addr); end
        n_cmp++; if (ifa.wr_addr !== 32'h0) begin n_bad++; $display("FAIL reset_wr_addr: got %h want 0", ifa.wr_addr); end
        n_cmp++; if (ifa.wr_data !== 32'h0) begin n_bad++; $display("FAIL reset_wr_data: got %h want 0", ifa.wr_data); end
        n_cmp++; if (ifa.inband_cons_index !== 12'h0) begin n_bad++; $display("FAIL reset_cons: got %h want 0", ifa.inband_cons_index); end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int k;
        logic [32:0] exp;
        do_reset();
        ifa.inband_prod_index = 12'd1;
        ifa.ring_enable = 1;
        k = 0;
        while (ifa.inband_cons_index !== 12'd1 && k < 100) begin @(negedge clk); k++; end
        n_cmp++; if (ifa.inband_cons_index !== 12'd1) begin n_bad++; $display("FAIL single_cons_timeout: got %h want 1", ifa.inband_cons_index); end
        n_cmp++; if (ifa.wr_req !== 1'b0) begin n_bad++; $display("FAIL single_wr_req_early: got %b want 0", ifa.wr_req); end
        @(negedge clk);
        n_cmp++; if (ifa.wr_req !== 1'b1) begin n_bad++; $display("FAIL single_wr_req_rise: got %b want 1", ifa.wr_req); end
        wait_a_wr(1, 50);
        repeat (12) @(negedge clk);
        n_cmp++; if (a_rd_log.size() !== 1) begin n_bad++; $display("FAIL single_rd_count: got %0d want 1", a_rd_log.size()); end
        if (a_rd_log.size() > 0) begin
            n_cmp++; if (a_rd_log[0] !== 32'h1000) begin n_bad++; $display("FAIL single_rd_addr: got %h want 00001000", a_rd_log[0]); end
        end
        n_cmp++; if (a_desc_log.size() !== 8) begin n_bad++; $display("FAIL single_word_count: got %0d want 8", a_desc_log.size()); end
        for (int i = 0; i < 8 && i < a_desc_log.size(); i++) begin
            exp = {(i == 7), 32'h1000 + 32'(i)};
            n_cmp++; if (a_desc_log[i] !== exp) begin n_bad++; $display("FAIL single_word%0d: got %h want %h", i, a_desc_log[i], exp); end
        end
        if (a_wr_data_log.size() > 0) begin
            n_cmp++; if (a_wr_data_log[0] !== 32'd1) begin n_bad++; $display("FAIL single_wr_data: got %h want 1", a_wr_data_log[0]); end
            n_cmp++; if (a_wr_addr_log[0] !== 32'h2000) begin n_bad++; $display("FAIL single_wr_addr: got %h want 00002000", a_wr_addr_log[0]); end
        end else begin
            n_cmp++; n_bad++; $display("FAIL single_wb_missing: got 0 write-backs want 1");
        end
        n_cmp++; if (ifa.desc_valid !== 1'b0) begin n_bad++; $display("FAIL single_drained: got %b want 0", ifa.desc_valid); end
    endtask

    task automatic test_wrap();
        int k;
        ifb.inband_prod_index = 12'd3;
        ifb.ring_enable = 1;
        k = 0;
        while (b_wr_log.size() < 3 && k < 300) begin @(negedge clk); k++; end
        n_cmp++; if (ifb.inband_cons_index !== 12'd3) begin n_bad++; $display("FAIL wrap_cons3: got %h want 3", ifb.inband_cons_index); end
        // 5 mod 4 = 1: two more descriptors, crossing the wrap.
        ifb.inband_prod_index = 12'd5;
        k = 0;
        while (b_wr_log.size() < 5 && k < 300) begin @(negedge clk); k++; end
        repeat (30) @(negedge clk);
        n_cmp++; if (b_rd_log.size() !== 5) begin n_bad++; $display("FAIL wrap_rd_count: got %0d want 5", b_rd_log.size()); end
        if (b_rd_log.size() >= 5) begin
            n_cmp++; if (b_rd_log[3] !== 32'h4060) begin n_bad++; $display("FAIL wrap_addr3: got %h want 00004060", b_rd_log[3]); end
            n_cmp++; if (b_rd_log[4] !== 32'h4000) begin n_bad++; $display("FAIL wrap_addr4: got %h want 00004000", b_rd_log[4]); end
        end
        if (b_wr_log.size() >= 5) begin
            n_cmp++; if (b_wr_log[3] !== 32'd0) begin n_bad++; $display("FAIL wrap_wb3: got %h want 0", b_wr_log[3]); end
            n_cmp++; if (b_wr_log[4] !== 32'd1) begin n_bad++; $display("FAIL wrap_wb4: got %h want 1", b_wr_log[4]); end
        end
        n_cmp++; if (ifb.inband_cons_index !== 12'd1) begin n_bad++; $display("FAIL wrap_cons_final: got %h want 1", ifb.inband_cons_index); end
        ifb.ring_enable = 0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int bad_words;
        logic [32:0] exp;
        do_reset();
        hold = 1;
        ifa.inband_prod_index = 12'd5;
        ifa.ring_enable = 1;
        repeat (200) @(negedge clk);
        n_cmp++; if (a_rd_log.size() !== 2) begin n_bad++; $display("FAIL bp_held_reads: got %0d want 2", a_rd_log.size()); end
        n_cmp++; if (ifa.rd_req !== 1'b0) begin n_bad++; $display("FAIL bp_rd_req_idle: got %b want 0", ifa.rd_req); end
        n_cmp++; if (ifa.inband_cons_index !== 12'd2) begin n_bad++; $display("FAIL bp_held_cons: got %h want 2", ifa.inband_cons_index); end
        n_cmp++; if (ifa.desc_valid !== 1'b1) begin n_bad++; $display("FAIL bp_held_valid: got %b want 1", ifa.desc_valid); end
        hold = 0;
        wait_a_wr(5, 600);
        repeat (20) @(negedge clk);
        n_cmp++; if (a_rd_log.size() !== 5) begin n_bad++; $display("FAIL bp_total_reads: got %0d want 5", a_rd_log.size()); end
        n_cmp++; if (a_desc_log.size() !== 40) begin n_bad++; $display("FAIL bp_total_words: got %0d want 40", a_desc_log.size()); end
        bad_words = 0;
        for (int i = 0; i < a_desc_log.size(); i++) begin
            exp = {((i % 8) == 7), 32'h1000 + 32'((i / 8) * 32) + 32'(i % 8)};
            if (a_desc_log[i] !== exp) bad_words++;
        end
        n_cmp++; if (bad_words !== 0) begin n_bad++; $display("FAIL bp_word_content: got %0d bad words want 0", bad_words); end
        for (int i = 0; i < a_wr_data_log.size(); i++) begin
            n_cmp++; if (a_wr_data_log[i] !== 32'(i + 1)) begin n_bad++; $display("FAIL bp_wb%0d: got %h want %h", i, a_wr_data_log[i], i + 1); end
        end
    endtask

    task automatic test_stall();
        int glitch;
        int k;
        logic [31:0] a0;
        logic [31:0] d0;
        do_reset();
        rd_stall = 20; wr_stall = 20;
        ifa.inband_prod_index = 12'd1;
        ifa.ring_enable = 1;
        wait_a_rd_req(50);
        a0 = ifa.rd_addr;
        n_cmp++; if (a0 !== 32'h1000) begin n_bad++; $display("FAIL stall_rd_addr: got %h want 00001000", a0); end
        glitch = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (ifa.rd_req !== 1'b1 || ifa.rd_addr !== 32'h1000) glitch++;
        end
        n_cmp++; if (glitch !== 0) begin n_bad++; $display("FAIL stall_rd_stable: got %0d unstable cycles want 0", glitch); end
        k = 0;
        while (ifa.wr_req !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        d0 = ifa.wr_data;
        n_cmp++; if (d0 !== 32'd1) begin n_bad++; $display("FAIL stall_wr_data: got %h want 1", d0); end
        glitch = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (ifa.wr_req !== 1'b1 || ifa.wr_data !== 32'd1 || ifa.wr_addr !== 32'h2000) glitch++;
        end
        n_cmp++; if (glitch !== 0) begin n_bad++; $display("FAIL stall_wr_stable: got %0d unstable cycles want 0", glitch); end
        wait_a_wr(1, 50);
        rd_stall = 0; wr_stall = 0;
        repeat (5) @(negedge clk);
        n_cmp++; if (ifa.wr_req !== 1'b0) begin n_bad++; $display("FAIL stall_wr_done: got %b want 0", ifa.wr_req); end
    endtask

    task automatic test_enable_drop();
        int k;
        do_reset();
        hold = 1;
        ifa.inband_prod_index = 12'd2;
        ifa.ring_enable = 1;
        wait_a_rd_req(50);
        repeat (4) @(negedge clk);
        ifa.ring_enable = 0;
        k = 0;
        while (ifa.wr_req !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        n_cmp++; if (ifa.wr_req !== 1'b1) begin n_bad++; $display("FAIL drop_wb_issued: got %b want 1", ifa.wr_req); end
        n_cmp++; if (ifa.desc_valid !== 1'b1) begin n_bad++; $display("FAIL drop_burst_buffered: got %b want 1", ifa.desc_valid); end
        wait_a_wr(1, 50);
        repeat (3) @(negedge clk);
        if (a_wr_data_log.size() > 0) begin
            n_cmp++; if (a_wr_data_log[0] !== 32'd1) begin n_bad++; $display("FAIL drop_wb_data: got %h want 1", a_wr_data_log[0]); end
        end else begin
            n_cmp++; n_bad++; $display("FAIL drop_wb_missing: got 0 write-backs want 1");
        end
        n_cmp++; if (ifa.inband_cons_index !== 12'd0) begin n_bad++; $display("FAIL drop_cons_cleared: got %h want 0", ifa.inband_cons_index); end
        n_cmp++; if (ifa.desc_valid !== 1'b0) begin n_bad++; $display("FAIL drop_fifo_flushed: got %b want 0", ifa.desc_valid); end
        repeat (30) @(negedge clk);
        n_cmp++; if (a_rd_log.size() !== 1) begin n_bad++; $display("FAIL drop_no_new_read: got %0d want 1", a_rd_log.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        hold = 1;
        ifa.inband_prod_index = 12'd1;
        ifa.ring_enable = 1;
        wait_a_rd_req(50);
        repeat (5) @(negedge clk);
        n_cmp++; if (ifa.desc_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_valid: got %b want 1", ifa.desc_valid); end
        rst_n = 0;
        #1;
        n_cmp++; if (ifa.rd_addr !== 32'h0) begin n_bad++; $display("FAIL rstmid_rd_addr: got %h want 0", ifa.rd_addr); end
        n_cmp++; if (ifa.rd_req !== 1'b0) begin n_bad++; $display("FAIL rstmid_rd_req: got %b want 0", ifa.rd_req); end
        n_cmp++; if (ifa.wr_req !== 1'b0) begin n_bad++; $display("FAIL rstmid_wr_req: got %b want 0", ifa.wr_req); end
        n_cmp++; if (ifa.desc_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_desc_valid: got %b want 0", ifa.desc_valid); end
        n_cmp++; if (ifa.desc_last !== 1'b0) begin n_bad++; $display("FAIL rstmid_desc_last: got %b want 0", ifa.desc_last); end
        n_cmp++; if (ifa.inband_cons_index !== 12'h0) begin n_bad++; $display("FAIL rstmid_cons: got %h want 0", ifa.inband_cons_index); end
        ifa.ring_enable = 0;
        repeat (12) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0;
        ifa.ring_enable = 0; ifa.inband_base = 32'h1000; ifa.inband_cons_addr = 32'h2000; ifa.inband_prod_index = 0;
        ifb.ring_enable = 0; ifb.inband_base = 32'h4000; ifb.inband_cons_addr = 32'h5000; ifb.inband_prod_index = 0;
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_stall();
        test_enable_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
